// File: rtl/alu_addsub_seq.sv
// Multi-cycle two's-complement add/subtract unit: one CHUNK-bit slice per cycle,
// carry held in a register between slices, Y86 flags produced on entry to DONE.
module alu_addsub_seq #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zf,
  output logic             sf,
  output logic             of,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // Handshake: start is sampled only while busy=0 (IDLE or DONE); busy is high
  // exactly while a slice is being added (RUN); done is a one-cycle pulse in DONE
  // and result/flags stay valid from that cycle until the next DONE or reset.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] opa, opb, acc;

  logic [31:0]      sh;
  logic [CHUNK-1:0] slice_a, slice_b;
  logic [CHUNK:0]   slice_sum;
  logic [WIDTH-1:0] slice_mask, acc_nx;
  logic             last, accept;

  // Slice k lives at bit offset k*CHUNK; the sum is merged into a copy of the
  // accumulator so the final edge can publish the complete result at once.
  always_comb begin
    sh         = 32'(cnt) * 32'(CHUNK);
    slice_a    = CHUNK'(opa >> sh);
    slice_b    = CHUNK'(opb >> sh);
    slice_sum  = {1'b0, slice_a} + {1'b0, slice_b} + (CHUNK+1)'(carry);
    slice_mask = WIDTH'({CHUNK{1'b1}});
    acc_nx     = (acc & ~(slice_mask << sh)) | (WIDTH'(slice_sum[CHUNK-1:0]) << sh);
    last       = (cnt == CW'(NCHUNK - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE, DONE: begin
        done     = (state == DONE);
        accept   = start;
        state_nx = start ? RUN : IDLE;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      carry  <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      acc    <= '0;
      result <= '0;
      cout   <= 1'b0;
      zf     <= 1'b0;
      sf     <= 1'b0;
      of     <= 1'b0;
    end else if (accept) begin
      // Subtract is A + ~B + 1: invert B here and seed the carry with op.
      opa   <= a;
      opb   <= b ^ {WIDTH{op}};
      carry <= op;
      cnt   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_nx;
      carry <= slice_sum[CHUNK];
      cnt   <= last ? '0 : cnt + CW'(1);
      if (last) begin
        result <= acc_nx;
        cout   <= slice_sum[CHUNK];
        zf     <= (acc_nx == '0);
        sf     <= acc_nx[WIDTH-1];
        // opb is already inverted for subtract, so one overflow rule serves both.
        of     <= (opa[WIDTH-1] == opb[WIDTH-1]) && (acc_nx[WIDTH-1] != opa[WIDTH-1]);
      end
    end
  end

endmodule
